// File: rtl/noc_packet_injector_if.sv
// Core-request and network-injection signals of noc_packet_injector.
// slave is the injector's view; master is the core/network side driving it.
interface noc_packet_injector_if #(
    parameter int unsigned packet_size = 16,
    parameter int unsigned fifo_depth  = 4
);
    localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;

    logic                   i_wr_valid;
    logic                   o_wr_ready;
    logic [2:0]             i_dest_x;
    logic [2:0]             i_dest_y;
    logic [9:0]             i_payload;
    logic [packet_size-1:0] o_data;
    logic                   o_data_valid;
    logic                   i_net_ready;
    logic [CNT_W-1:0]       o_count;
    logic [7:0]             o_drop_cnt;

    modport slave (
        input  i_wr_valid, i_dest_x, i_dest_y, i_payload, i_net_ready,
        output o_wr_ready, o_data, o_data_valid, o_count, o_drop_cnt
    );

    modport master (
        output i_wr_valid, i_dest_x, i_dest_y, i_payload, i_net_ready,
        input  o_wr_ready, o_data, o_data_valid, o_count, o_drop_cnt
    );
endinterface

// File: rtl/noc_packet_injector.sv
// Packs core requests into {dest_y, dest_x, payload} NoC packets, buffers them and injects them.
// Optional macro INJ_DEST_CHECK_EN: drop out-of-mesh destinations and count them in o_drop_cnt.
module noc_packet_injector #(
    parameter int unsigned packet_size = 16,
    parameter int unsigned xno         = 8,
    parameter int unsigned yno         = 8,
    parameter int unsigned fifo_depth  = 4,
    parameter int unsigned gap         = 0
) (
    input  logic                    clk,
    input  logic                    i_reset,
    noc_packet_injector_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(fifo_depth);
    localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t                 state_q, state_d;
    logic [packet_size-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   wr_ready_q;
    logic [packet_size-1:0] data_q;
    logic                   valid_q, valid_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   accept_c, push_c, pop_c;
    logic                   dest_in_range_c, dest_ok_c;

    assign accept_c        = bus.i_wr_valid && wr_ready_q;
    assign dest_in_range_c = (32'(bus.i_dest_x) < xno) && (32'(bus.i_dest_y) < yno);
    assign push_c          = accept_c && dest_ok_c;

    // Injection FSM: IDLE pops the head, SEND holds under backpressure, GAP idles
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (valid_q && bus.i_net_ready) begin
                    if (gap == 0) begin
                        if (count_q != '0) begin
                            pop_c = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else if (gap == 1) begin
                        // the single idle cycle is the IDLE visit itself
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        valid_d = 1'b0;
                        gap_d   = GAP_W'(gap - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                valid_d = 1'b0;
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy: push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            gap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
            wr_ready_q <= (count_d != CNT_W'(fifo_depth));
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                data_q   <= mem[rd_ptr_q];
            end
        end
    end

    // Storage array is not reset; occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= packet_size'({bus.i_dest_y, bus.i_dest_x, bus.i_payload});
    end

`ifdef INJ_DEST_CHECK_EN
    logic [7:0] drop_q;
    assign dest_ok_c = dest_in_range_c;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            drop_q <= 8'h00;
        end else if (accept_c && !dest_in_range_c && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end

    assign bus.o_drop_cnt = drop_q;
`else
    logic dest_unused_c;
    assign dest_unused_c  = dest_in_range_c;
    assign dest_ok_c      = 1'b1;
    assign bus.o_drop_cnt = 8'h00;
`endif

    assign bus.o_wr_ready   = wr_ready_q;
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_count      = count_q;
endmodule
